// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiplier arbiter slice.
// Contents: FSM state encoding, operand/product widths, the operand payload
// struct and the helper that sizes the requester-index field.
package vedic_pkg;

  localparam int unsigned OPW   = 32;  // operand width
  localparam int unsigned PRODW = 64;  // full product width
  localparam int unsigned CNTW  = 4;   // COMPUTE down-counter width (MUL_LAT <= 15)
  localparam int unsigned DONEW = 16;  // completed-response counter width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  // Registered operand pair for the operation in flight.
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } operand_t;

  // Width of an index able to name n requesters (never narrower than 1 bit).
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vedic32x32.sv
// 32x32 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier, purely combinational.
// Ports:
//   a, b  : 32-bit unsigned operands
//   gnd   : ground input, folded in as a zero carry-in
//   prod  : 64-bit unsigned product a*b
module vedic32x32
  import vedic_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  input  logic             gnd,
  output logic [PRODW-1:0] prod
);

  localparam int unsigned HW = OPW / 2;

  logic [OPW-1:0] pp_ll;
  logic [OPW-1:0] pp_lh;
  logic [OPW-1:0] pp_hl;
  logic [OPW-1:0] pp_hh;

  // Vertical and crosswise 16x16 partial products.
  always_comb begin
    pp_ll = OPW'(a[HW-1:0])   * OPW'(b[HW-1:0]);
    pp_lh = OPW'(a[HW-1:0])   * OPW'(b[OPW-1:HW]);
    pp_hl = OPW'(a[OPW-1:HW]) * OPW'(b[HW-1:0]);
    pp_hh = OPW'(a[OPW-1:HW]) * OPW'(b[OPW-1:HW]);
  end

  // Align and sum the partial products; ground enters as the carry-in.
  always_comb begin
    prod = PRODW'(pp_ll)
         + (PRODW'(pp_lh) << HW)
         + (PRODW'(pp_hl) << HW)
         + (PRODW'(pp_hh) << OPW)
         + PRODW'(gnd);
  end

endmodule

// File: rtl/vedic_mult_arbiter.sv
// Round-robin arbiter sharing one 32x32 Vedic multiplier among N_REQ requesters.
// One operation is in flight at a time: IDLE grants, COMPUTE waits MUL_LAT
// cycles, RESP holds the product until the consumer takes it.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   req_valid/req_ready  : per-requester handshake (req_ready combinational, one-hot or zero)
//   req_a, req_b         : packed 32-bit operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready  : product handshake
//   rsp_prod, rsp_id     : product and owning requester index
//   busy                 : high whenever not IDLE
//   done_cnt             : wrapping count of retired responses
module vedic_mult_arbiter
  import vedic_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [OPW*N_REQ-1:0]         req_a,
  input  logic [OPW*N_REQ-1:0]         req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [PRODW-1:0]             rsp_prod,
  output logic [id_width(N_REQ)-1:0]   rsp_id,
  output logic                         busy,
  output logic [DONEW-1:0]             done_cnt
);

  localparam int unsigned IDW = id_width(N_REQ);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       sync_q;
  logic             run;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [IDW-1:0]   id_q;
  logic [CNTW-1:0]  cnt;
  operand_t         op_q;
  logic [PRODW-1:0] mul_prod;
  logic             accept;
  logic             capture;
  logic             retire;
  logic [OPW-1:0]   a_arr [N_REQ];
  logic [OPW-1:0]   b_arr [N_REQ];

  // Unpack the flat operand buses per requester.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*OPW +: OPW];
    assign b_arr[i] = req_b[i*OPW +: OPW];
  end

  // Reset-release synchroniser: assertion is immediate, release takes two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

  // Round-robin search: first valid requester at or above rr_ptr, modulo N_REQ.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run && grant_found) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_nxt            = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand/grant capture, compute countdown, product capture and status outputs.
  // The counter is loaded with MUL_LAT and the product is taken on the edge
  // after it reaches zero, so rsp_valid appears MUL_LAT+1 edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      id_q      <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (accept) begin
        op_q.a <= a_arr[grant_idx];
        op_q.b <= b_arr[grant_idx];
        id_q   <= grant_idx;
        rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        cnt    <= CNTW'(MUL_LAT);
      end else if (state == ST_COMPUTE && cnt != '0) begin
        cnt <= cnt - CNTW'(1);
      end
      if (capture) begin
        rsp_prod <= mul_prod;
        rsp_id   <= id_q;
      end
      if (retire) done_cnt <= done_cnt + DONEW'(1);
      rsp_valid <= (state_nxt == ST_RESP);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  vedic32x32 u_mul (
    .a    (op_q.a),
    .b    (op_q.b),
    .gnd  (1'b0),
    .prod (mul_prod)
  );

endmodule
